// File: rtl/nco_sweep_ctrl_if.sv
// Control/status and phase_accumulator-side signals of the NCO sweep controller.
interface nco_sweep_ctrl_if #(
    parameter int unsigned FCW_W   = 20,
    parameter int unsigned NSTEP_W = 10,
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               abort;
    logic [FCW_W-1:0]   cfg_fcw_start;
    logic [FCW_W-1:0]   cfg_fcw_step;
    logic [NSTEP_W-1:0] cfg_num_steps;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_loop;
    logic               nco_vld;
    logic               nco_en;
    logic [FCW_W-1:0]   nco_fcw;
    logic               busy;
    logic               done;
    logic [NSTEP_W-1:0] step_idx;

    modport master (
        output start, abort, cfg_fcw_start, cfg_fcw_step, cfg_num_steps,
               cfg_dwell, cfg_loop, nco_vld,
        input  nco_en, nco_fcw, busy, done, step_idx
    );

    modport slave (
        input  start, abort, cfg_fcw_start, cfg_fcw_step, cfg_num_steps,
               cfg_dwell, cfg_loop, nco_vld,
        output nco_en, nco_fcw, busy, done, step_idx
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Linear FCW sweep sequencer driving the serial phase_accumulator En/FCW inputs.
// Optional NCO_SWEEP_PINGPONG_EN: walk back down to index 0 after the last step.
module nco_sweep_ctrl #(
    parameter int unsigned FCW_W   = 20,
    parameter int unsigned NSTEP_W = 10,
    parameter int unsigned DWELL_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    nco_sweep_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [FCW_W-1:0]   fcw_q, fcw_d;
    logic               busy_q;
    logic               done_q, done_d;
    logic [NSTEP_W-1:0] idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               ld_c;

    logic [FCW_W-1:0]   sh_start, sh_step;
    logic [NSTEP_W-1:0] sh_last;
    logic [DWELL_W-1:0] sh_dwell;
    logic               sh_loop;

    logic [DWELL_W-1:0] dwell_inc_c;
    logic [NSTEP_W-1:0] idx_up_c, idx_dn_c;
    logic [FCW_W-1:0]   fcw_up_c, fcw_dn_c;

    assign dwell_inc_c = dwell_q + DWELL_W'(1);
    assign idx_up_c    = idx_q + NSTEP_W'(1);
    assign idx_dn_c    = idx_q - NSTEP_W'(1);
    assign fcw_up_c    = fcw_q + sh_step;
    assign fcw_dn_c    = fcw_q - sh_step;

`ifdef NCO_SWEEP_PINGPONG_EN
    logic dir_q, dir_d;
`endif

    // Sweep configuration captured at start; zero count/dwell act as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_start <= '0;
            sh_step  <= '0;
            sh_last  <= '0;
            sh_dwell <= DWELL_W'(1);
            sh_loop  <= 1'b0;
        end else if (ld_c) begin
            sh_start <= bus.cfg_fcw_start;
            sh_step  <= bus.cfg_fcw_step;
            sh_last  <= (bus.cfg_num_steps == '0) ? '0 : bus.cfg_num_steps - NSTEP_W'(1);
            sh_dwell <= (bus.cfg_dwell == '0) ? DWELL_W'(1) : bus.cfg_dwell;
            sh_loop  <= bus.cfg_loop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            fcw_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            dwell_q <= '0;
`ifdef NCO_SWEEP_PINGPONG_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            fcw_q   <= fcw_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
`ifdef NCO_SWEEP_PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        fcw_d   = fcw_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        ld_c    = 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
        dir_d   = dir_q;
`endif
        if (bus.abort) begin
            state_d = IDLE;
            en_d    = 1'b0;
            idx_d   = '0;
            dwell_d = '0;
`ifdef NCO_SWEEP_PINGPONG_EN
            dir_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        ld_c    = 1'b1;
                        fcw_d   = bus.cfg_fcw_start;
                        idx_d   = '0;
                        dwell_d = '0;
                        en_d    = 1'b1;
                        state_d = RUN;
`ifdef NCO_SWEEP_PINGPONG_EN
                        dir_d   = 1'b0;
`endif
                    end
                end
                RUN: begin
                    // FCW moves only on a Vld edge, so each frame uses a stable FCW.
                    if (bus.nco_vld) begin
                        if (dwell_inc_c == sh_dwell) begin
                            dwell_d = '0;
`ifdef NCO_SWEEP_PINGPONG_EN
                            if (!dir_q && idx_q != sh_last) begin
                                idx_d = idx_up_c;
                                fcw_d = fcw_up_c;
                            end else if (dir_q && idx_q != '0) begin
                                idx_d = idx_dn_c;
                                fcw_d = fcw_dn_c;
                            end else if (!dir_q && sh_last != '0) begin
                                dir_d = 1'b1;
                                idx_d = idx_dn_c;
                                fcw_d = fcw_dn_c;
                            end else if (sh_loop) begin
                                dir_d = 1'b0;
                                idx_d = '0;
                                fcw_d = sh_start;
                            end else begin
                                state_d = DRAIN;
                            end
`else
                            if (idx_q != sh_last) begin
                                idx_d = idx_up_c;
                                fcw_d = fcw_up_c;
                            end else if (sh_loop) begin
                                idx_d = '0;
                                fcw_d = sh_start;
                            end else begin
                                state_d = DRAIN;
                            end
`endif
                        end else begin
                            dwell_d = dwell_inc_c;
                        end
                    end
                end
                DRAIN: begin
                    // Hold En until the last frame's phase has been serialized.
                    if (bus.nco_vld) begin
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.nco_en   = en_q;
    assign bus.nco_fcw  = fcw_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_idx = idx_q;

endmodule
